// File: rtl/cdb_slot_scheduler_pkg.sv
// Shared definitions for the CDB slot scheduler.
//   LAT_W      : width of one per-FU latency field in FU_LAT
//   ID_W       : width of an FU index for the default FU count
//   FU_LAT_DEF : default latencies {FU3, FU2, FU1, FU0} = {6, 3, 0, 0}
//   slot_t     : one reservation-slot record {valid, id}
package cdb_sched_pkg;

  localparam int NUM_FU_DEF  = 4;
  localparam int MAX_LAT_DEF = 8;
  localparam int LAT_W       = $clog2(MAX_LAT_DEF + 1);
  localparam int ID_W        = $clog2(NUM_FU_DEF);

  localparam logic [NUM_FU_DEF*LAT_W-1:0] FU_LAT_DEF = {4'd6, 4'd3, 4'd0, 4'd0};

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } slot_t;

endpackage

// File: rtl/cdb_slot_scheduler_if.sv
// Issue/CDB bundle between the FU issue logic and the CDB slot scheduler.
//   i_ready     : per-FU instruction ready
//   i_fu_busy   : per-FU non-pipelined unit busy
//   o_issue     : per-FU issue grant (combinational)
//   o_cdb_valid : CDB carries a result this cycle
//   o_cdb_fu_id : owner of the CDB this cycle, 0 when idle
// master drives requests, slave is the scheduler.
interface cdb_slot_scheduler_if
  import cdb_sched_pkg::*;
#(
  parameter int NUM_FU  = NUM_FU_DEF,
  parameter int FU_ID_W = ID_W
);

  logic [NUM_FU-1:0]  i_ready;
  logic [NUM_FU-1:0]  i_fu_busy;
  logic [NUM_FU-1:0]  o_issue;
  logic               o_cdb_valid;
  logic [FU_ID_W-1:0] o_cdb_fu_id;

  modport master (
    output i_ready, i_fu_busy,
    input  o_issue, o_cdb_valid, o_cdb_fu_id
  );

  modport slave (
    input  i_ready, i_fu_busy,
    output o_issue, o_cdb_valid, o_cdb_fu_id
  );

endinterface

// File: rtl/cdb_slot_scheduler_rr_pick.sv
// Rotating-priority picker: grants the first asserted request found when
// scanning upward from ptr and wrapping around.
//   req : request vector
//   ptr : index that has highest priority this cycle (< NUM_FU)
//   gnt : one-hot grant, zero when no request
module cdb_rr_pick
  import cdb_sched_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF
) (
  input  logic [NUM_FU-1:0]         req,
  input  logic [$clog2(NUM_FU)-1:0] ptr,
  output logic [NUM_FU-1:0]         gnt
);

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    gnt = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_FU]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NUM_FU] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_slot_scheduler.sv
// CDB slot scheduler: issues FUs so that no two results ever meet on the
// common data bus in the same cycle. A shift register of future CDB slots
// records which cycles are already claimed and by which FU.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_flush        : (only with CDB_SCHED_FLUSH_EN) drop grants, CDB and
//                    all reservations this cycle
//   bus            : cdb_slot_scheduler_if.slave (ready/busy in, issue/CDB out)
// Optional feature macro: CDB_SCHED_FLUSH_EN.
module cdb_slot_scheduler
  import cdb_sched_pkg::*;
#(
  parameter int                      NUM_FU  = NUM_FU_DEF,
  parameter int                      MAX_LAT = MAX_LAT_DEF,
  parameter logic [NUM_FU*LAT_W-1:0] FU_LAT  = FU_LAT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
`ifdef CDB_SCHED_FLUSH_EN
  input  logic i_flush,
`endif
  cdb_slot_scheduler_if.slave bus
);

  localparam int FU_ID_W = $clog2(NUM_FU);

  typedef struct packed {
    logic               valid;
    logic [FU_ID_W-1:0] id;
  } rsv_t;

  function automatic int lat_of(input int fu);
    return int'(FU_LAT[fu*LAT_W +: LAT_W]);
  endfunction

  // True for the lowest-indexed FU of each latency group; that FU hosts
  // the group's picker.
  function automatic bit lat_leader(input int fu);
    bit lead;
    lead = 1'b1;
    for (int j = 0; j < fu; j++) begin
      if (lat_of(j) == lat_of(fu)) lead = 1'b0;
    end
    return lead;
  endfunction

  logic flush;
`ifdef CDB_SCHED_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  rsv_t [MAX_LAT-1:0]              slot_q, slot_d;
  logic [FU_ID_W-1:0]              rr_q, rr_d;
  logic [NUM_FU-1:0]               elig, gnt;
  logic [NUM_FU-1:0][NUM_FU-1:0]   gnt_grp;
  logic                            cdb_v;
  logic [FU_ID_W-1:0]              cdb_id;

  // Eligibility: a max-latency FU lands one beyond the reservation window,
  // which is always free.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_elig
    localparam int L = lat_of(i);
    if (L >= MAX_LAT) begin : g_far
      assign elig[i] = bus.i_ready[i] & ~bus.i_fu_busy[i] & ~flush;
    end else begin : g_near
      assign elig[i] = bus.i_ready[i] & ~bus.i_fu_busy[i] & ~slot_q[L].valid & ~flush;
    end
  end

  // One picker per distinct latency: FUs sharing a latency would collide on
  // the same future slot, FUs with different latencies never do.
  for (genvar g = 0; g < NUM_FU; g++) begin : g_grp
    if (lat_leader(g)) begin : g_pick
      logic [NUM_FU-1:0] req;
      for (genvar j = 0; j < NUM_FU; j++) begin : g_req
        assign req[j] = (lat_of(j) == lat_of(g)) ? elig[j] : 1'b0;
      end
      cdb_rr_pick #(.NUM_FU(NUM_FU)) u_pick (
        .req (req),
        .ptr (rr_q),
        .gnt (gnt_grp[g])
      );
    end else begin : g_none
      assign gnt_grp[g] = '0;
    end
  end

  always_comb begin
    gnt = '0;
    for (int g = 0; g < NUM_FU; g++) gnt = gnt | gnt_grp[g];
  end

  // Pointer moves past the first grant seen in rotating order.
  always_comb begin
    logic found;
    found = 1'b0;
    rr_d  = rr_q;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!found && gnt[(int'(rr_q) + k) % NUM_FU]) begin
        found = 1'b1;
        rr_d  = FU_ID_W'((int'(rr_q) + k + 1) % NUM_FU);
      end
    end
  end

  // Window advances one cycle; a latency-L grant claims slot L-1 of the
  // shifted window. Eligibility guarantees the claimed slot is empty.
  always_comb begin
    slot_d = '0;
    for (int k = 0; k < MAX_LAT - 1; k++) slot_d[k] = slot_q[k+1];
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i] && lat_of(i) > 0) begin
        slot_d[lat_of(i)-1] = '{valid: 1'b1, id: FU_ID_W'(i)};
      end
    end
  end

  // Current CDB owner: an earlier reservation or a latency-0 grant, never
  // both because a latency-0 FU is ineligible while slot 0 is taken.
  always_comb begin
    cdb_v  = slot_q[0].valid;
    cdb_id = slot_q[0].valid ? slot_q[0].id : '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (gnt[i] && lat_of(i) == 0) begin
        cdb_v  = 1'b1;
        cdb_id = FU_ID_W'(i);
      end
    end
  end

  assign bus.o_issue     = gnt;
  assign bus.o_cdb_valid = cdb_v & ~flush;
  assign bus.o_cdb_fu_id = flush ? '0 : cdb_id;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || flush) begin
      slot_q <= '0;
      rr_q   <= '0;
    end else begin
      slot_q <= slot_d;
      rr_q   <= rr_d;
    end
  end

endmodule

// File: tb/tb_cdb_slot_scheduler.sv
// Bench for cdb_slot_scheduler with the default FU latencies {6,3,0,0}.
// The reference model keeps a calendar of future CDB cycles (absolute cycle
// number -> owning FU) and grants by scanning FUs in rotating order.
module tb_cdb_slot_scheduler;
  import cdb_sched_pkg::*;

  localparam int N  = 4;
  localparam int ML = 8;
  localparam int LAT [N] = '{0, 0, 3, 6};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
`ifdef CDB_SCHED_FLUSH_EN
  logic flush = 1'b0;
`endif

  cdb_slot_scheduler_if #(.NUM_FU(N), .FU_ID_W(2)) bus();

  cdb_slot_scheduler #(
    .NUM_FU  (N),
    .MAX_LAT (ML),
    .FU_LAT  ({4'd6, 4'd3, 4'd0, 4'd0})
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
`ifdef CDB_SCHED_FLUSH_EN
    .i_flush (flush),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int cal [int];
  int rr_m   = 0;
  int tcyc   = 0;
  bit mdl_ok = 1'b0;

  logic [31:0] g_issue, g_v, g_id;

  // One clock cycle: drive at negedge, sample shortly after, check against
  // the model, then advance the model as the following posedge will.
  task automatic step(input logic [3:0] rdy, input logic [3:0] bsy,
                      input logic rn, input logic fl);
    logic [31:0] e_issue;
    int  e_v, e_id, first, i;
    bit  fl_eff;
    @(negedge clk);
    bus.i_ready   = rdy;
    bus.i_fu_busy = bsy;
    rst_n         = rn;
`ifdef CDB_SCHED_FLUSH_EN
    flush  = fl;
    fl_eff = fl;
`else
    fl_eff = fl & 1'b0;
`endif
    #2;
    g_issue = 32'(bus.o_issue);
    g_v     = 32'(bus.o_cdb_valid);
    g_id    = 32'(bus.o_cdb_fu_id);

    e_issue = '0;
    first   = -1;
    if (!fl_eff) begin
      for (int k = 0; k < N; k++) begin
        i = (rr_m + k) % N;
        if (rdy[i] && !bsy[i] && !cal.exists(tcyc + LAT[i])) begin
          e_issue[i] = 1'b1;
          cal[tcyc + LAT[i]] = i;
          if (first < 0) first = i;
        end
      end
    end
    e_v  = (cal.exists(tcyc) && !fl_eff) ? 1 : 0;
    e_id = e_v ? cal[tcyc] : 0;

    if (mdl_ok) begin
      chk("mdl_issue", g_issue, e_issue);
      chk("mdl_cdb_valid", g_v, e_v);
      chk("mdl_cdb_id", g_id, e_id);
    end

    if (cal.exists(tcyc)) cal.delete(tcyc);
    if (first >= 0) rr_m = (first + 1) % N;
    if (!rn || fl_eff) begin
      cal.delete();
      rr_m = 0;
    end
    if (!rn) mdl_ok = 1'b1;
    tcyc++;
  endtask

  initial begin
    bus.i_ready   = '0;
    bus.i_fu_busy = '0;

    // Reset state
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    chk("rst_issue", g_issue, 0);
    chk("rst_cdb_valid", g_v, 0);

    // Two latency-0 FUs alternate, each result on the CDB immediately
    for (int k = 0; k < 4; k++) begin
      step(4'b0011, 4'h0, 1'b1, 1'b0);
      chk("alt_issue", g_issue, (k % 2) ? 2 : 1);
      chk("alt_cdb_valid", g_v, 1);
      chk("alt_cdb_id", g_id, k % 2);
    end

    // All ready at once: one per latency group, pointer to 1
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'b1111, 4'h0, 1'b1, 1'b0);
    chk("all_issue", g_issue, 'b1101);
    chk("all_cdb_id", g_id, 0);
    step(4'b0011, 4'h0, 1'b1, 1'b0);
    chk("all_rr", g_issue, 'b0010);

    // FU2 result at t+3 blocks FU0 that cycle
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'b0100, 4'h0, 1'b1, 1'b0);
    chk("l3_issue", g_issue, 'b0100);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'b0001, 4'h0, 1'b1, 1'b0);
    chk("l3_block_issue", g_issue, 0);
    chk("l3_cdb_valid", g_v, 1);
    chk("l3_cdb_id", g_id, 2);
    step(4'b0001, 4'h0, 1'b1, 1'b0);
    chk("l3_retry_issue", g_issue, 'b0001);
    chk("l3_retry_id", g_id, 0);

    // FU3's reservation blocks FU2 three cycles later
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'b1000, 4'h0, 1'b1, 1'b0);
    chk("l6_issue", g_issue, 'b1000);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'b0100, 4'h0, 1'b1, 1'b0);
    chk("l6_deny", g_issue, 0);
    step(4'b0100, 4'h0, 1'b1, 1'b0);
    chk("l6_late_grant", g_issue, 'b0100);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    chk("l6_cdb_id3", g_id, 3);
    chk("l6_cdb_v3", g_v, 1);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    chk("l6_cdb_id2", g_id, 2);
    chk("l6_cdb_v2", g_v, 1);

    // Busy FU never issues; clearing busy grants in the same cycle
    step(4'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(4'b1000, 4'b1000, 1'b1, 1'b0);
      chk("busy_issue", g_issue, 0);
    end
    step(4'b1000, 4'h0, 1'b1, 1'b0);
    chk("unbusy_issue", g_issue, 'b1000);

    // Reset in flight discards the pending FU3 result
    step(4'h0, 4'h0, 1'b0, 1'b0);
    step(4'b1000, 4'h0, 1'b1, 1'b0);
    chk("rstmid_issue", g_issue, 'b1000);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    chk("rstmid_cdb_valid", g_v, 0);

`ifdef CDB_SCHED_FLUSH_EN
    // Flush in flight discards the pending FU3 result
    step(4'b1000, 4'h0, 1'b1, 1'b0);
    chk("flush_issue", g_issue, 'b1000);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'b0011, 4'h0, 1'b1, 1'b1);
    chk("flush_gate_issue", g_issue, 0);
    chk("flush_gate_v", g_v, 0);
    for (int k = 0; k < 3; k++) step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0);
    chk("flush_cdb_valid", g_v, 0);
`endif

    // Randomized traffic against the calendar model
    for (int k = 0; k < 3000; k++) begin
      step(4'($urandom), 4'($urandom & $urandom),
           ($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_slot_scheduler.md
CDB_SLOT_SCHEDULER -- requirements
Module: cdb_slot_scheduler

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, number of functional units (FUs) competing for the CDB, range 2..8.
REQ-002 SHALL have parameter MAX_LAT, default 8, maximum FU latency in cycles, range 1..15.
REQ-003 SHALL have parameter FU_LAT, default {6,3,0,0} (FU3..FU0), packed NUM_FU x LAT_W field giving each FU's issue-to-CDB latency, each 0..MAX_LAT.
REQ-004 i_clk  input  1  clock; reset i_rst_n, synchronous, active-low.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_ready  input  NUM_FU  FU i has an instruction ready to issue.
REQ-007 i_fu_busy  input  NUM_FU  FU i is non-pipelined and currently executing.
REQ-008 o_issue  output  NUM_FU  grant: FU i issues this cycle.
REQ-009 o_cdb_valid  output  1  the CDB carries a result this cycle.
REQ-010 o_cdb_fu_id  output  ID_W  index of the FU owning the CDB this cycle; 0 when o_cdb_valid=0.

Function
REQ-011 SHALL hold reservation vector S[MAX_LAT-1:0]: S[k]=1 means the CDB is reserved at cycle t+k by an earlier grant, with an ID_W owner tag per slot.
REQ-012 FU i with latency L SHALL be eligible iff i_ready[i] & ~i_fu_busy[i] & (L==MAX_LAT | ~S[L]).
REQ-013 Among eligible FUs sharing the same L, exactly one SHALL be granted: the first in rotating order starting at pointer rr.
REQ-014 FUs with different latencies SHALL be granted in the same cycle when all are eligible.
REQ-015 o_issue SHALL be combinational in the same cycle as i_ready; FU i SHALL never be granted when not eligible.
REQ-016 Next state SHALL be S'[k] = S[k+1] | grant-with-latency k+1, with S[MAX_LAT]=0; the owner tag SHALL follow the same shift.
REQ-017 o_cdb_valid SHALL be S[0] | (a latency-0 FU granted this cycle); o_cdb_fu_id SHALL be S[0]'s tag, otherwise the granted latency-0 FU.
REQ-018 A latency-0 grant and S[0] SHALL be mutually exclusive, so there is never more than one CDB owner per cycle.
REQ-019 On any cycle with at least one grant, rr SHALL update to (g+1) mod NUM_FU, where g is the first granted FU in rotating order from rr; otherwise rr SHALL hold.
REQ-020 An ineligible FU SHALL hold no state; it retries each cycle while i_ready stays high.

Reset
REQ-021 While i_rst_n=0 at a clock edge: S=0, all tags=0, rr=0; o_issue=0 and o_cdb_valid=0 in the following cycle unless new inputs produce a grant.
REQ-022 Reset mid-operation SHALL discard all pending reservations; no pre-reset result SHALL appear on o_cdb_valid.

Configuration
REQ-023 Macro CDB_SCHED_FLUSH_EN SHALL add input i_flush (1 bit): i_flush=1 forces o_issue=0 and o_cdb_valid=0 in that cycle, and S, tags and rr clear at the edge.
REQ-024 Without CDB_SCHED_FLUSH_EN, the i_flush port and logic SHALL be absent and behaviour is REQ-011..020 only.

Structure
REQ-025 Package cdb_sched_pkg SHALL hold LAT_W=$clog2(MAX_LAT+1), ID_W=$clog2(NUM_FU), the default FU_LAT constant, and a slot typedef {valid, id}.
REQ-026 Sub-module cdb_rr_pick (rotating-priority picker, request vector plus pointer -> one-hot grant) SHALL be instantiated once per distinct latency group.

Verification (defaults: FU0=0, FU1=0, FU2=3, FU3=6)
REQ-027 After reset, i_ready=4'b0011 held for 4 cycles -> o_issue = 0001, 0010, 0001, 0010; o_cdb_valid=1 each cycle with id 0,1,0,1.
REQ-028 FU2 granted at t -> o_cdb_valid=1 and id=2 at t+3; i_ready[0]=1 at t+3 -> o_issue[0]=0 at t+3 and 1 at t+4.
REQ-029 FU3 granted at t, i_ready[2]=1 at t+3 -> FU2 denied at t+3 (slot t+6 taken) and granted at t+4; CDB at t+6 has id 3 and at t+7 id 2.
REQ-030 i_ready=4'b1000 with i_fu_busy[3]=1 for 5 cycles -> o_issue=0 throughout; deasserting busy gives a grant the same cycle.
REQ-031 FU3 granted at t, i_rst_n=0 at t+2 (or i_flush=1 with CDB_SCHED_FLUSH_EN) -> o_cdb_valid=0 at t+6.
REQ-032 i_ready=4'b1111 in one cycle after reset -> o_issue=4'b1101 (FU0, FU2 and FU3 granted; FU1 loses on latency 0); rr=1.
